// File: rtl/div32_pkg.sv
// Shared constants, state encoding and helpers for the 32-bit iterative divider.
// Build option: SIGNED_DIV_EN selects two's-complement operands (default unsigned).
package div32_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned COUNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient reported for a zero divisor
  localparam logic [WIDTH-1:0] DIV0_Q = {WIDTH{1'b1}};

  // Two's-complement magnitude; 32'h8000_0000 maps to itself, which is the
  // correct unsigned magnitude
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(~x + 1'b1) : x;
  endfunction

  // Conditional two's-complement negate
  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] x,
                                                    input logic            neg);
    return neg ? WIDTH'(~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/divider_32bit_div_step.sv
// One restoring shift-and-subtract step: shift in the next dividend bit, try
// subtracting the divisor, keep the difference when it does not borrow.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction with an explicit borrow in the top bit
  always_comb begin
    shifted = {rem_in[WIDTH-1:0], bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/divider_32bit.sv
// Multi-cycle 32-bit divider, one quotient bit per clock, start/done handshake.
// Build option: SIGNED_DIV_EN enables truncating two's-complement division.
module divider_32bit
  import div32_pkg::*;
#(
  parameter int unsigned WIDTH = div32_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(WIDTH - 1);

  state_t             state;
  logic [COUNT_W-1:0] count;
  logic [WIDTH-1:0]   q_sr;
  logic [WIDTH:0]     p_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   a_raw;
  logic               dz;
`ifdef SIGNED_DIV_EN
  logic               neg_q;
  logic               neg_r;
`endif

  logic [WIDTH:0]     rem_next;
  logic               q_bit;
  logic [WIDTH-1:0]   q_next;
  logic [WIDTH-1:0]   q_final;
  logic [WIDTH-1:0]   r_final;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (p_reg),
    .bit_in  (q_sr[WIDTH-1]),
    .divisor (b_reg),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // Result of the current step, with sign fix-up when signed division is built
  always_comb begin
    q_next = {q_sr[WIDTH-2:0], q_bit};
`ifdef SIGNED_DIV_EN
    q_final = cond_negate(q_next, neg_q);
    r_final = cond_negate(rem_next[WIDTH-1:0], neg_r);
`else
    q_final = q_next;
    r_final = rem_next[WIDTH-1:0];
`endif
  end

  // Control FSM, iteration datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      q_sr        <= '0;
      p_reg       <= '0;
      b_reg       <= '0;
      a_raw       <= '0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef SIGNED_DIV_EN
            q_sr  <= magnitude(A);
            b_reg <= magnitude(B);
            neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
            neg_r <= A[WIDTH-1];
`else
            q_sr  <= A;
            b_reg <= B;
`endif
            a_raw <= A;
            p_reg <= '0;
            dz    <= (B == '0);
            // A zero divisor takes a single pass through RUN so done lands
            // one cycle after acceptance
            count <= (B == '0) ? LAST_COUNT : '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          p_reg <= rem_next;
          q_sr  <= q_next;
          count <= count + 1'b1;
          if (count == LAST_COUNT) begin
            state       <= DONE;
            done        <= 1'b1;
            Q           <= dz ? DIV0_Q : q_final;
            R           <= dz ? a_raw  : r_final;
            div_by_zero <= dz;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_32bit.sv
// Self-checking bench for divider_32bit: directed and random operations against
// a plain-arithmetic reference, handshake timing, ignored starts and reset abort.
module tb_divider_32bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Q;
  logic [31:0] R;
  logic        div_by_zero;

  int checks = 0;
  int fails  = 0;

  logic [31:0] prev_q;
  logic [31:0] prev_r;
  logic        prev_dz;

  divider_32bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .Q           (Q),
    .R           (R),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result from the arithmetic definition of the operation
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      dz = 1'b1;
    end else begin
      dz = 1'b0;
`ifdef SIGNED_DIV_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Run one operation; optionally pulse a foreign start mid-run
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit pulse_mid);
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    int          lat;
    model(a, b, eq, er, edz);
    lat = (b == 32'd0) ? 1 : 32;
    @(negedge clk);
    start = 1'b1;
    A = a;
    B = b;
    @(negedge clk);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    for (int k = 0; k <= lat + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (pulse_mid && k == 5) begin
        start = 1'b1;
        A = 32'd1000;
        B = 32'd3;
      end else begin
        start = 1'b0;
      end
      chk("busy", 32'(busy), 32'(k <= lat));
      chk("done", 32'(done), 32'(k == lat));
      if (k < lat) begin
        chk("q_held", Q, prev_q);
        chk("r_held", R, prev_r);
        chk("dz_held", 32'(div_by_zero), 32'(prev_dz));
      end else begin
        chk("q", Q, eq);
        chk("r", R, er);
        chk("dz", 32'(div_by_zero), 32'(edz));
      end
    end
    start = 1'b0;
    prev_q = eq;
    prev_r = er;
    prev_dz = edz;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    prev_q = '0;
    prev_r = '0;
    prev_dz = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", Q, 32'd0);
    chk("rst_r", R, 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    do_op(32'd100, 32'd7, 1'b0);
    do_op(32'h1234_5678, 32'd0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(32'd5, 32'd9, 1'b0);
    do_op(32'd123456, 32'd789, 1'b1);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Reset in the middle of a run aborts it and clears the results
    @(negedge clk);
    start = 1'b1;
    A = 32'd999;
    B = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", Q, 32'd0);
    chk("abort_r", R, 32'd0);
    chk("abort_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_q = '0;
    prev_r = '0;
    prev_dz = 1'b0;
    do_op(32'd77, 32'd5, 1'b0);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 255));
        2: rb = (i == 6) ? 32'd0 : 32'($urandom_range(1, 65535));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      do_op(ra, rb, (i % 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
